// File: rtl/cpu_io_host_pkg.sv
// Shared encodings for the cpu io host: command ops, injected opcodes and FSM states.
package cpu_io_host_pkg;

   localparam int BIT_OP = 4;

   localparam logic [1:0] CMD_LOAD     = 2'b00;
   localparam logic [1:0] CMD_EXEC     = 2'b01;
   localparam logic [1:0] CMD_EXEC_CAP = 2'b10;
   localparam logic [1:0] CMD_RSVD     = 2'b11;

   localparam logic [BIT_OP-1:0] OP_LDI   = 4'hE;
   localparam logic [15:0]       INST_NOP = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_INJECT = 3'd2,
      ST_WAIT   = 3'd3,
      ST_HOLD   = 3'd4
   } state_e;

endpackage

// File: rtl/cpu_io_host_if.sv
// Host-side command / load-data / capture-readback bus of the cpu io host.
interface cpu_io_host_if #(
   parameter int BIT_INST = 16,
   parameter int BIT_DATA = 16,
   parameter int SZB_INS  = 4
) ();
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_op;
   logic [SZB_INS:0]    cmd_len;
   logic [BIT_INST-1:0] cmd_inst;
   logic [BIT_DATA-1:0] cmd_data;
   logic                wr_valid;
   logic                wr_ready;
   logic [BIT_DATA-1:0] wr_data;
   logic                rd_valid;
   logic                rd_ready;
   logic [BIT_DATA-1:0] rd_data;
   logic                cmd_err;

   modport master (
      output cmd_valid, cmd_op, cmd_len, cmd_inst, cmd_data, wr_valid, wr_data, rd_ready,
      input  cmd_ready, wr_ready, rd_valid, rd_data, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_len, cmd_inst, cmd_data, wr_valid, wr_data, rd_ready,
      output cmd_ready, wr_ready, rd_valid, rd_data, cmd_err
   );
endinterface

// File: rtl/cpu_io_host_io_capture_reg.sv
// Capture delay counter and the rd_valid/rd_data holding register for EXEC_CAP readback.
module io_capture_reg #(
   parameter int BIT_DATA = 16,
   parameter int CAP_LAT  = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [BIT_DATA-1:0] io_dout,
   input  logic                rd_ready,
   output logic                cap_fire,
   output logic                rd_take,
   output logic                rd_valid,
   output logic [BIT_DATA-1:0] rd_data
);
   localparam logic [2:0] CNT_INIT = 3'(CAP_LAT - 1);

   logic [2:0]          cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                rd_valid_q, rd_valid_d;
   logic [BIT_DATA-1:0] rd_data_q, rd_data_d;

   assign cap_fire = busy_q & (cnt_q == 3'd0);
   assign rd_take  = rd_valid_q & rd_ready;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

   // Count down after injection, sample io_dout at zero, then hold until consumed.
   always_comb begin
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = CNT_INIT;
      end else if (cap_fire) begin
         busy_d     = 1'b0;
         rd_valid_d = 1'b1;
         rd_data_d  = io_dout;
      end else if (busy_q) begin
         cnt_d = cnt_q - 3'd1;
      end else if (rd_take) begin
         rd_valid_d = 1'b0;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= 3'd0;
         busy_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= {BIT_DATA{1'b0}};
      end else begin
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end
endmodule

// File: rtl/cpu_io_host.sv
// Host-side driver of the cpu io port: turns LOAD / EXEC / EXEC_CAP commands into
// interrupt-driven io cycles and returns captured io_dout words.
module cpu_io_host
   import cpu_io_host_pkg::*;
#(
   parameter int BIT_INST = 16,
   parameter int BIT_DATA = 16,
   parameter int SZB_INS  = 4,
   parameter int CAP_LAT  = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   cpu_io_host_if.slave        host,
   output logic                interrupt,
   output logic [BIT_INST-1:0] io_inst,
   output logic [BIT_DATA-1:0] io_din,
   input  logic [BIT_DATA-1:0] io_dout
);
   localparam int               DEPTH   = 2 ** SZB_INS;
   localparam int               PADW    = BIT_INST - BIT_OP - SZB_INS;
   localparam logic [SZB_INS:0] LEN_MAX = (SZB_INS + 1)'(DEPTH);
   localparam logic [SZB_INS:0] LEN_ONE = {{SZB_INS{1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic                cap_q, cap_d;
   logic [SZB_INS:0]    len_q, len_d;
   logic [SZB_INS:0]    k_q, k_d;
   logic                interrupt_q, interrupt_d;
   logic [BIT_INST-1:0] io_inst_q, io_inst_d;
   logic [BIT_DATA-1:0] io_din_q, io_din_d;
   logic                cmd_err_q, cmd_err_d;

   logic cmd_ready_s, wr_ready_s, cmd_acc_s, wr_acc_s, cmd_bad_s, last_word_s;
   logic cap_start_s, cap_fire_s, rd_take_s;

   assign cmd_ready_s = (state_q == ST_IDLE);
   assign wr_ready_s  = (state_q == ST_LOAD);
   assign cmd_acc_s   = host.cmd_valid & cmd_ready_s;
   assign wr_acc_s    = host.wr_valid & wr_ready_s;
   assign last_word_s = (k_q == (len_q - LEN_ONE));
   assign cap_start_s = (state_q == ST_INJECT) & cap_q;
   // A zero-length or over-depth LOAD is dropped so the load index can never wrap.
   assign cmd_bad_s   = (host.cmd_op == CMD_RSVD) ||
                        ((host.cmd_op == CMD_LOAD) &&
                         ((host.cmd_len == {(SZB_INS + 1){1'b0}}) || (host.cmd_len > LEN_MAX)));

   assign host.cmd_ready = cmd_ready_s;
   assign host.wr_ready  = wr_ready_s;
   assign host.cmd_err   = cmd_err_q;
   assign interrupt      = interrupt_q;
   assign io_inst        = io_inst_q;
   assign io_din         = io_din_q;

   io_capture_reg #(
      .BIT_DATA (BIT_DATA),
      .CAP_LAT  (CAP_LAT)
   ) u_capture (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (cap_start_s),
      .io_dout  (io_dout),
      .rd_ready (host.rd_ready),
      .cap_fire (cap_fire_s),
      .rd_take  (rd_take_s),
      .rd_valid (host.rd_valid),
      .rd_data  (host.rd_data)
   );

   // State register and load bookkeeping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cap_q   <= 1'b0;
         len_q   <= {(SZB_INS + 1){1'b0}};
         k_q     <= {(SZB_INS + 1){1'b0}};
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         len_q   <= len_d;
         k_q     <= k_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      len_d   = len_q;
      k_d     = k_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_acc_s && !cmd_bad_s) begin
               if (host.cmd_op == CMD_LOAD) begin
                  state_d = ST_LOAD;
                  len_d   = host.cmd_len;
                  k_d     = {(SZB_INS + 1){1'b0}};
               end else begin
                  state_d = ST_INJECT;
                  cap_d   = (host.cmd_op == CMD_EXEC_CAP);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (wr_acc_s && last_word_s) begin
               state_d = ST_IDLE;
               k_d     = {(SZB_INS + 1){1'b0}};
            end else if (wr_acc_s) begin
               k_d = k_q + LEN_ONE;
            end else begin
               k_d = k_q;
            end
         end
         ST_INJECT: begin
            if (cap_q) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cap_fire_s) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (rd_take_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Io output values; gaps mid-load keep interrupt high with a NOP so the cpu stays parked.
   always_comb begin
      interrupt_d = 1'b0;
      io_inst_d   = io_inst_q;
      io_din_d    = io_din_q;
      cmd_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_acc_s && cmd_bad_s) begin
               cmd_err_d = 1'b1;
            end else if (cmd_acc_s && (host.cmd_op != CMD_LOAD)) begin
               interrupt_d = 1'b1;
               io_inst_d   = host.cmd_inst;
               io_din_d    = host.cmd_data;
            end else begin
               interrupt_d = 1'b0;
            end
         end
         ST_LOAD: begin
            interrupt_d = 1'b1;
            if (wr_acc_s) begin
               io_inst_d = {OP_LDI, {PADW{1'b0}}, k_q[SZB_INS-1:0]};
               io_din_d  = host.wr_data;
            end else begin
               io_inst_d = INST_NOP;
            end
         end
         default: interrupt_d = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         interrupt_q <= 1'b0;
         io_inst_q   <= {BIT_INST{1'b0}};
         io_din_q    <= {BIT_DATA{1'b0}};
         cmd_err_q   <= 1'b0;
      end else begin
         interrupt_q <= interrupt_d;
         io_inst_q   <= io_inst_d;
         io_din_q    <= io_din_d;
         cmd_err_q   <= cmd_err_d;
      end
   end
endmodule
